// File: rtl/cam_write_arbiter_pkg.sv
// Shared camera definitions: default frame geometry, arbiter state encoding
// and the constant-stride address helper.
package cam_write_arbiter_pkg;

    localparam int CAM_LINE_STRIDE = 160;
    localparam int CAM_LINES       = 240;
    localparam int CAM2_BASE_ADDR  = 38400;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT1 = 2'd1,
        ST_GRANT2 = 2'd2
    } arb_state_t;

    // stride is always a constant at the call site, so this folds into a few shifted adds
    function automatic logic [31:0] stride_mul(input logic [31:0] line, input logic [31:0] stride);
        logic [31:0] acc;
        acc = 32'd0;
        for (int i = 0; i < 32; i++) begin
            if (stride[i]) begin
                acc = acc + (line << i);
            end else begin
                acc = acc;
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/cam_pix_fifo.sv
// Per-camera pixel queue: power-of-two depth, wrap-bit pointers, a push into a full
// queue is accepted only when a pop happens in the same cycle.
module cam_pix_fifo
    import cam_write_arbiter_pkg::*;
#(
    parameter int WIDTH = 29,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_empty,
    output logic             o_full,
    output logic             o_drop
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_pop_ok;
    logic             w_push_ok;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop_ok  = i_pop && !o_empty;
    assign w_push_ok = i_push && (!o_full || w_pop_ok);
    assign o_drop    = i_push && o_full && !w_pop_ok;
    assign o_dout    = r_mem[r_rd_ptr[AW-1:0]];

    // Storage write; contents need no reset since the pointers gate visibility
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_din;
        end
    end

    // Pointer update
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/cam_write_arbiter.sv
// Merges two camera pixel streams into a single frame-buffer write port through
// per-camera queues and a round-robin arbiter gated by a write-slot enable.
module cam_write_arbiter
    import cam_write_arbiter_pkg::*;
#(
    parameter int CAM_DATA_WIDTH = 12,
    parameter int CAM_LINE       = 9,
    parameter int CAM_PIXEL      = 10,
    parameter int ADDR_WIDTH     = 17,
    parameter int LINE_STRIDE    = CAM_LINE_STRIDE,
    parameter int LINES          = CAM_LINES,
    parameter int CAM2_BASE      = CAM2_BASE_ADDR,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                      clk,
    input  logic                      i_rst_n,
    input  logic                      i_we_cam1,
    input  logic                      i_we_cam2,
    input  logic [CAM_DATA_WIDTH-1:0] i_data_cam1_wr,
    input  logic [CAM_DATA_WIDTH-1:0] i_data_cam2_wr,
    input  logic [CAM_LINE-1:0]       i_line_cam1,
    input  logic [CAM_LINE-1:0]       i_line_cam2,
    input  logic [CAM_PIXEL-1:0]      i_pixel_cam1,
    input  logic [CAM_PIXEL-1:0]      i_pixel_cam2,
    input  logic                      i_enable,
    output logic                      o_we,
    output logic [ADDR_WIDTH-1:0]     o_addr_wr,
    output logic [CAM_DATA_WIDTH-1:0] o_data_wr,
    output logic [1:0]                o_overflow,
    output logic [1:0]                o_range_err,
    input  logic                      i_clear
);

    localparam int          EW        = ADDR_WIDTH + CAM_DATA_WIDTH;
    localparam logic [31:0] LP_STRIDE = 32'(LINE_STRIDE);
    localparam logic [31:0] LP_LINES  = 32'(LINES);
    localparam logic [31:0] LP_BASE2  = 32'(CAM2_BASE);

    logic [1:0]                     w_strobe;
    logic [1:0][CAM_LINE-1:0]       w_line;
    logic [1:0][CAM_PIXEL-1:0]      w_pixel;
    logic [1:0][CAM_DATA_WIDTH-1:0] w_data;
    logic [1:0][ADDR_WIDTH-1:0]     w_addr;
    logic [1:0][EW-1:0]             w_head;
    logic [1:0]                     w_in_range;
    logic [1:0]                     w_push;
    logic [1:0]                     w_pop;
    logic [1:0]                     w_empty;
    logic [1:0]                     w_full;
    logic [1:0]                     w_drop;
    logic [1:0]                     w_range_hit;
    logic                           w_prefer2;
    arb_state_t                     w_state_next;

    arb_state_t                     r_state;
    logic                           r_rr_cam2;
    logic                           r_we;
    logic [ADDR_WIDTH-1:0]          r_addr;
    logic [CAM_DATA_WIDTH-1:0]      r_data;
    logic [1:0]                     r_overflow;
    logic [1:0]                     r_range_err;

    assign w_strobe = {i_we_cam2, i_we_cam1};
    assign w_line   = {i_line_cam2, i_line_cam1};
    assign w_pixel  = {i_pixel_cam2, i_pixel_cam1};
    assign w_data   = {i_data_cam2_wr, i_data_cam1_wr};

    for (genvar c = 0; c < 2; c++) begin : g_cam
        localparam logic [31:0] LP_OFFSET = (c == 1) ? LP_BASE2 : 32'd0;

        assign w_in_range[c]  = (32'(w_pixel[c]) < LP_STRIDE) && (32'(w_line[c]) < LP_LINES);
        assign w_addr[c]      = ADDR_WIDTH'(stride_mul(32'(w_line[c]), LP_STRIDE) + 32'(w_pixel[c]) + LP_OFFSET);
        assign w_push[c]      = w_strobe[c] & w_in_range[c];
        assign w_range_hit[c] = w_strobe[c] & ~w_in_range[c];

        cam_pix_fifo #(
            .WIDTH (EW),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk     (clk),
            .i_rst_n (i_rst_n),
            .i_push  (w_push[c]),
            .i_din   ({w_addr[c], w_data[c]}),
            .i_pop   (w_pop[c]),
            .o_dout  (w_head[c]),
            .o_empty (w_empty[c]),
            .o_full  (w_full[c]),
            .o_drop  (w_drop[c])
        );
    end

    // Round-robin preference: alternate after a grant, otherwise keep the remembered turn
    always_comb begin
        w_prefer2 = r_rr_cam2;
        case (r_state)
            ST_GRANT1: w_prefer2 = 1'b1;
            ST_GRANT2: w_prefer2 = 1'b0;
            default:   w_prefer2 = r_rr_cam2;
        endcase
    end

    // Grant decision for this cycle; the granted queue pops immediately
    always_comb begin
        w_state_next = ST_IDLE;
        w_pop        = 2'b00;
        if (!i_enable || (w_empty == 2'b11)) begin
            w_state_next = ST_IDLE;
        end else if (w_empty == 2'b00) begin
            w_state_next = w_prefer2 ? ST_GRANT2 : ST_GRANT1;
        end else if (!w_empty[0]) begin
            w_state_next = ST_GRANT1;
        end else begin
            w_state_next = ST_GRANT2;
        end
        case (w_state_next)
            ST_GRANT1: w_pop = 2'b01;
            ST_GRANT2: w_pop = 2'b10;
            default:   w_pop = 2'b00;
        endcase
    end

    // State, write port and sticky error flags; a new error beats a same-cycle clear
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_rr_cam2   <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_data      <= '0;
            r_overflow  <= 2'b00;
            r_range_err <= 2'b00;
        end else begin
            r_state     <= w_state_next;
            r_we        <= (w_state_next != ST_IDLE);
            r_overflow  <= (r_overflow & ~{2{i_clear}}) | (w_drop & ~w_full | w_drop);
            r_range_err <= (r_range_err & ~{2{i_clear}}) | w_range_hit;
            case (w_state_next)
                ST_GRANT1: begin
                    r_addr    <= w_head[0][EW-1:CAM_DATA_WIDTH];
                    r_data    <= w_head[0][CAM_DATA_WIDTH-1:0];
                    r_rr_cam2 <= 1'b1;
                end
                ST_GRANT2: begin
                    r_addr    <= w_head[1][EW-1:CAM_DATA_WIDTH];
                    r_data    <= w_head[1][CAM_DATA_WIDTH-1:0];
                    r_rr_cam2 <= 1'b0;
                end
                default: begin
                    r_addr    <= r_addr;
                    r_data    <= r_data;
                    r_rr_cam2 <= r_rr_cam2;
                end
            endcase
        end
    end

    assign o_we        = r_we;
    assign o_addr_wr   = r_addr;
    assign o_data_wr   = r_data;
    assign o_overflow  = r_overflow;
    assign o_range_err = r_range_err;

endmodule

// File: tb/tb_cam_write_arbiter.sv
// Directed self-checking bench for cam_write_arbiter with hand-computed expectations.
module tb_cam_write_arbiter;

    logic        clk;
    logic        i_rst_n;
    logic        i_we_cam1, i_we_cam2;
    logic [11:0] i_data_cam1_wr, i_data_cam2_wr;
    logic [8:0]  i_line_cam1, i_line_cam2;
    logic [9:0]  i_pixel_cam1, i_pixel_cam2;
    logic        i_enable;
    logic        o_we;
    logic [16:0] o_addr_wr;
    logic [11:0] o_data_wr;
    logic [1:0]  o_overflow;
    logic [1:0]  o_range_err;
    logic        i_clear;

    int checks = 0;
    int errors = 0;

    logic [29:0] obs;
    logic [29:0] exp_v;

    cam_write_arbiter dut (
        .clk            (clk),
        .i_rst_n        (i_rst_n),
        .i_we_cam1      (i_we_cam1),
        .i_we_cam2      (i_we_cam2),
        .i_data_cam1_wr (i_data_cam1_wr),
        .i_data_cam2_wr (i_data_cam2_wr),
        .i_line_cam1    (i_line_cam1),
        .i_line_cam2    (i_line_cam2),
        .i_pixel_cam1   (i_pixel_cam1),
        .i_pixel_cam2   (i_pixel_cam2),
        .i_enable       (i_enable),
        .o_we           (o_we),
        .o_addr_wr      (o_addr_wr),
        .o_data_wr      (o_data_wr),
        .o_overflow     (o_overflow),
        .o_range_err    (o_range_err),
        .i_clear        (i_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic idle_inputs();
        i_we_cam1 = 1'b0; i_we_cam2 = 1'b0;
        i_data_cam1_wr = 12'h000; i_data_cam2_wr = 12'h000;
        i_line_cam1 = 9'd0; i_line_cam2 = 9'd0;
        i_pixel_cam1 = 10'd0; i_pixel_cam2 = 10'd0;
        i_enable = 1'b1; i_clear = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        i_rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        i_rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        idle_inputs();
        @(negedge clk);
        obs = {o_we, o_addr_wr, o_data_wr};
        if (obs !== 30'd0) begin
            errors++; $display("FAIL reset_port: got %h expected %h", obs, 30'd0);
        end
        checks++;
        if ({o_overflow, o_range_err} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags: got %b expected 0000", {o_overflow, o_range_err});
        end
        checks++;
        i_rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        if (o_we !== 1'b0) begin
            errors++; $display("FAIL reset_idle_we: got %b expected 0", o_we);
        end
        checks++;
    endtask

    task automatic test_single_write();
        do_reset();
        i_we_cam1 = 1'b1; i_line_cam1 = 9'd2; i_pixel_cam1 = 10'd5; i_data_cam1_wr = 12'hABC;
        @(negedge clk);
        i_we_cam1 = 1'b0;
        if (o_we !== 1'b0) begin
            errors++; $display("FAIL single_early: got o_we=%b expected 0", o_we);
        end
        checks++;
        @(negedge clk);
        obs = {o_we, o_addr_wr, o_data_wr}; exp_v = {1'b1, 17'd325, 12'hABC};
        if (obs !== exp_v) begin
            errors++; $display("FAIL single_write: got %h expected %h", obs, exp_v);
        end
        checks++;
        @(negedge clk);
        obs = {o_we, o_addr_wr, o_data_wr}; exp_v = {1'b0, 17'd325, 12'hABC};
        if (obs !== exp_v) begin
            errors++; $display("FAIL single_hold: got %h expected %h", obs, exp_v);
        end
        checks++;
    endtask

    task automatic test_round_robin();
        do_reset();
        i_we_cam1 = 1'b1; i_data_cam1_wr = 12'h111;
        i_we_cam2 = 1'b1; i_data_cam2_wr = 12'h222;
        @(negedge clk);
        i_we_cam1 = 1'b0; i_we_cam2 = 1'b0;
        @(negedge clk);
        obs = {o_we, o_addr_wr, o_data_wr}; exp_v = {1'b1, 17'd0, 12'h111};
        if (obs !== exp_v) begin
            errors++; $display("FAIL rr_first_cam1: got %h expected %h", obs, exp_v);
        end
        checks++;
        @(negedge clk);
        obs = {o_we, o_addr_wr, o_data_wr}; exp_v = {1'b1, 17'd38400, 12'h222};
        if (obs !== exp_v) begin
            errors++; $display("FAIL rr_second_cam2: got %h expected %h", obs, exp_v);
        end
        checks++;
        @(negedge clk);
        if (o_we !== 1'b0) begin
            errors++; $display("FAIL rr_done: got o_we=%b expected 0", o_we);
        end
        checks++;
    endtask

    task automatic test_back_to_back();
        logic [16:0] exp_addr [4];
        exp_addr[0] = 17'd1; exp_addr[1] = 17'd38403; exp_addr[2] = 17'd2; exp_addr[3] = 17'd38404;
        do_reset();
        i_enable = 1'b0;
        for (int i = 0; i < 2; i++) begin
            i_we_cam1 = 1'b1; i_pixel_cam1 = 10'(1 + i); i_data_cam1_wr = 12'(12'h310 + i);
            i_we_cam2 = 1'b1; i_pixel_cam2 = 10'(3 + i); i_data_cam2_wr = 12'(12'h320 + i);
            @(negedge clk);
        end
        i_we_cam1 = 1'b0; i_we_cam2 = 1'b0; i_enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            exp_v = {1'b1, exp_addr[i], ((i % 2) == 0) ? 12'(12'h310 + i / 2) : 12'(12'h320 + i / 2)};
            obs = {o_we, o_addr_wr, o_data_wr};
            if (obs !== exp_v) begin
                errors++; $display("FAIL b2b_write%0d: got %h expected %h", i, obs, exp_v);
            end
            checks++;
        end
    endtask

    task automatic test_overflow();
        do_reset();
        i_enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            i_we_cam2 = 1'b1; i_line_cam2 = 9'd1; i_pixel_cam2 = 10'(i); i_data_cam2_wr = 12'(12'h500 + i);
            @(negedge clk);
            if (o_we !== 1'b0) begin
                errors++; $display("FAIL ovf_disabled_we%0d: got %b expected 0", i, o_we);
            end
            checks++;
        end
        i_we_cam2 = 1'b0;
        if (o_overflow !== 2'b10) begin
            errors++; $display("FAIL ovf_flag: got %b expected 10", o_overflow);
        end
        checks++;
        i_enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            obs = {o_we, o_addr_wr, o_data_wr}; exp_v = {1'b1, 17'(38560 + i), 12'(12'h500 + i)};
            if (obs !== exp_v) begin
                errors++; $display("FAIL ovf_write%0d: got %h expected %h", i, obs, exp_v);
            end
            checks++;
        end
        @(negedge clk);
        obs = {o_we, o_addr_wr, o_data_wr}; exp_v = {1'b0, 17'd38563, 12'h503};
        if (obs !== exp_v) begin
            errors++; $display("FAIL ovf_no_fifth: got %h expected %h", obs, exp_v);
        end
        checks++;
        i_clear = 1'b1;
        @(negedge clk);
        i_clear = 1'b0;
        if (o_overflow !== 2'b00) begin
            errors++; $display("FAIL ovf_clear: got %b expected 00", o_overflow);
        end
        checks++;
    endtask

    task automatic test_range();
        do_reset();
        i_we_cam1 = 1'b1; i_pixel_cam1 = 10'd160; i_data_cam1_wr = 12'hFFF;
        @(negedge clk);
        i_we_cam1 = 1'b0;
        if (o_range_err !== 2'b01) begin
            errors++; $display("FAIL range_flag: got %b expected 01", o_range_err);
        end
        checks++;
        @(negedge clk);
        if (o_we !== 1'b0) begin
            errors++; $display("FAIL range_no_write: got o_we=%b expected 0", o_we);
        end
        checks++;
        i_clear = 1'b1;
        @(negedge clk);
        i_clear = 1'b0;
        if (o_range_err !== 2'b00) begin
            errors++; $display("FAIL range_clear: got %b expected 00", o_range_err);
        end
        checks++;
        i_we_cam2 = 1'b1; i_line_cam2 = 9'd240; i_pixel_cam2 = 10'd0;
        @(negedge clk);
        i_we_cam2 = 1'b0;
        i_clear = 1'b1;
        i_we_cam1 = 1'b1; i_line_cam1 = 9'd240; i_pixel_cam1 = 10'd0;
        @(negedge clk);
        i_clear = 1'b0; i_we_cam1 = 1'b0;
        if (o_range_err !== 2'b01) begin
            errors++; $display("FAIL range_clear_vs_set: got %b expected 01", o_range_err);
        end
        checks++;
        i_we_cam1 = 1'b1; i_line_cam1 = 9'd239; i_pixel_cam1 = 10'd159; i_data_cam1_wr = 12'h5A5;
        @(negedge clk);
        i_we_cam1 = 1'b0;
        @(negedge clk);
        obs = {o_we, o_addr_wr, o_data_wr}; exp_v = {1'b1, 17'd38399, 12'h5A5};
        if (obs !== exp_v) begin
            errors++; $display("FAIL range_last_pixel: got %h expected %h", obs, exp_v);
        end
        checks++;
    endtask

    task automatic test_full_push_pop();
        do_reset();
        i_enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            i_we_cam1 = 1'b1; i_pixel_cam1 = 10'(i); i_data_cam1_wr = 12'(12'h100 + i);
            @(negedge clk);
        end
        i_enable = 1'b1; i_pixel_cam1 = 10'd4; i_data_cam1_wr = 12'h104;
        @(negedge clk);
        i_we_cam1 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            obs = {o_we, o_addr_wr, o_data_wr}; exp_v = {1'b1, 17'(i), 12'(12'h100 + i)};
            if (obs !== exp_v) begin
                errors++; $display("FAIL full_pp_write%0d: got %h expected %h", i, obs, exp_v);
            end
            checks++;
            @(negedge clk);
        end
        if ({o_we, o_overflow} !== 3'b000) begin
            errors++; $display("FAIL full_pp_end: got %b expected 000", {o_we, o_overflow});
        end
        checks++;
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        i_enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            i_we_cam1 = 1'b1; i_pixel_cam1 = 10'(i); i_data_cam1_wr = 12'(12'h700 + i);
            @(negedge clk);
        end
        i_we_cam1 = 1'b0; i_enable = 1'b1;
        @(negedge clk);
        if (o_we !== 1'b1) begin
            errors++; $display("FAIL rst_burst_started: got o_we=%b expected 1", o_we);
        end
        checks++;
        #1;
        i_rst_n = 1'b0;
        #1;
        obs = {o_we, o_addr_wr, o_data_wr};
        if (obs !== 30'd0) begin
            errors++; $display("FAIL rst_async: got %h expected %h", obs, 30'd0);
        end
        checks++;
        @(negedge clk);
        i_rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (o_we !== 1'b0) begin
                errors++; $display("FAIL rst_no_write%0d: got o_we=%b expected 0", i, o_we);
            end
            checks++;
        end
    endtask

    initial begin
        i_rst_n = 1'b0;
        idle_inputs();
        test_reset();
        test_single_write();
        test_round_robin();
        test_back_to_back();
        test_overflow();
        test_range();
        test_full_push_pop();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
